// File: rtl/if_id_queue_pkg.sv
// Shared types for the IF/ID decoupling queue: entry layout, default sizing and occupancy states.
// Imported by the interface, the queue and its testbench.
package if_id_queue_pkg;

    localparam int IF_ID_DEPTH_DEFAULT = 4;
    localparam int INSTR_W_DEFAULT     = 32;
    localparam int ADDR_W_DEFAULT      = 64;

    typedef logic [INSTR_W_DEFAULT-1:0] word_t;
    typedef logic [ADDR_W_DEFAULT-1:0]  addr_t;

    typedef struct packed {
        word_t instr;
        addr_t pc;
        logic  pred_taken;
    } if_id_entry_t;

    // Occupancy classes; the exact fill level lives in the count register.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_PART  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: IF push side, ID pop side and queue status.
// master drives the request side (fetch/decode control), slave is the queue itself.
interface if_id_queue_if #(
    parameter int DEPTH   = if_id_queue_pkg::IF_ID_DEPTH_DEFAULT,
    parameter int INSTR_W = if_id_queue_pkg::INSTR_W_DEFAULT,
    parameter int ADDR_W  = if_id_queue_pkg::ADDR_W_DEFAULT
);

    logic                       flush;
    logic                       freeze;
    logic                       ihit;
    logic [INSTR_W-1:0]         instr_if;
    logic [ADDR_W-1:0]          pc_if;
    logic                       pred_taken_if;
    logic                       full;
    logic                       id_ready;
    logic                       valid_id;
    logic [INSTR_W-1:0]         instr_id;
    logic [ADDR_W-1:0]          pc_id;
    logic                       pred_taken_id;
    logic [$clog2(DEPTH+1)-1:0] count;

    modport master (
        output flush, freeze, ihit, instr_if, pc_if, pred_taken_if, id_ready,
        input  full, valid_id, instr_id, pc_id, pred_taken_id, count
    );

    modport slave (
        input  flush, freeze, ihit, instr_if, pc_if, pred_taken_if, id_ready,
        output full, valid_id, instr_id, pc_id, pred_taken_id, count
    );

endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO decoupling fetch from decode, with flush squash and freeze hold of the head.
// Define IF_ID_QUEUE_BYPASS_EN to let an empty queue forward the IF entry to ID in the same cycle.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH   = IF_ID_DEPTH_DEFAULT,
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT
) (
    input  logic          CLK,
    input  logic          RST,
    if_id_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               pred_taken;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count_q;
    occ_state_e        occ_q, occ_d;

    logic full_w, valid_w, bypass_hit;
    logic push_fire, pop_fire, byp_consume, do_push, do_pop;

    assign full_w = (occ_q == OCC_FULL);

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass_hit = (occ_q == OCC_EMPTY) & q.ihit & ~q.flush;
`else
    assign bypass_hit = 1'b0;
`endif

    assign valid_w   = (occ_q != OCC_EMPTY) | bypass_hit;
    assign push_fire = q.ihit & ~full_w;
    assign pop_fire  = valid_w & q.id_ready & ~q.freeze;

    // A bypassed entry consumed by ID in the same cycle never touches storage.
    assign byp_consume = bypass_hit & pop_fire;
    assign do_push     = push_fire & ~byp_consume;
    assign do_pop      = pop_fire  & ~byp_consume;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) occ_q <= OCC_EMPTY;
        else     occ_q <= occ_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        occ_d = occ_q;
        if (q.flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: if (do_push && !do_pop) occ_d = OCC_PART;
                OCC_PART: begin
                    if (count_q == CNT_LAST && do_push && !do_pop)     occ_d = OCC_FULL;
                    else if (count_q == CNT_ONE && do_pop && !do_push) occ_d = OCC_EMPTY;
                end
                OCC_FULL:  if (do_pop) occ_d = OCC_PART;
                default:   occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_comb begin
        q.full          = full_w;
        q.valid_id      = valid_w;
        q.count         = count_q;
        q.instr_id      = '0;
        q.pc_id         = '0;
        q.pred_taken_id = 1'b0;
        if (bypass_hit) begin
            q.instr_id      = q.instr_if;
            q.pc_id         = q.pc_if;
            q.pred_taken_id = q.pred_taken_if;
        end else if (occ_q != OCC_EMPTY) begin
            q.instr_id      = mem[rd_ptr].instr;
            q.pc_id         = mem[rd_ptr].pc;
            q.pred_taken_id = mem[rd_ptr].pred_taken;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || q.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

    // NOTE: storage is deliberately left out of reset; only the count/pointers define which slots are live.
    always_ff @(posedge CLK) begin
        if (!RST && !q.flush && do_push) begin
            mem[wr_ptr] <= '{instr: q.instr_if, pc: q.pc_if, pred_taken: q.pred_taken_if};
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = IF_ID_DEPTH_DEFAULT;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH), .INSTR_W(32), .ADDR_W(64)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .INSTR_W(32), .ADDR_W(64)) dut (
        .CLK (clk),
        .RST (rst),
        .q   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit model_live = 1'b0;
    if_id_entry_t model_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare outputs to the model, advance the model.
    task automatic cycle(input logic r, input logic fl, input logic fr, input logic ih,
                         input addr_t pc, input logic rdy);
        if_id_entry_t in_e, head;
        int  sz;
        bit  byp, push, pop;
        @(negedge clk);
        in_e.instr      = $urandom;
        in_e.pc         = pc;
        in_e.pred_taken = 1'($urandom_range(0, 1));
        rst               = r;
        bus.flush         = fl;
        bus.freeze        = fr;
        bus.ihit          = ih;
        bus.id_ready      = rdy;
        bus.instr_if      = in_e.instr;
        bus.pc_if         = in_e.pc;
        bus.pred_taken_if = in_e.pred_taken;
        #1;
        sz   = model_q.size();
        byp  = BYPASS && (sz == 0) && ih && !fl;
        head = '0;
        if (sz != 0) head = model_q[0];
        else if (byp) head = in_e;
        if (model_live) begin
            check("count",      64'(bus.count),         64'(sz));
            check("full",       64'(bus.full),          64'(sz == DEPTH));
            check("valid_id",   64'(bus.valid_id),      64'((sz != 0) || byp));
            check("instr_id",   64'(bus.instr_id),      64'(head.instr));
            check("pc_id",      bus.pc_id,              head.pc);
            check("pred_taken", 64'(bus.pred_taken_id), 64'(head.pred_taken));
        end
        if (r) begin
            model_q.delete();
            model_live = 1'b1;
        end else if (fl) begin
            model_q.delete();
        end else begin
            push = ih && (sz < DEPTH);
            pop  = ((sz != 0) || byp) && rdy && !fr;
            if (!(byp && pop)) begin
                if (pop)  void'(model_q.pop_front());
                if (push) model_q.push_back(in_e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.freeze = 1'b0; bus.ihit = 1'b0; bus.id_ready = 1'b0;
        bus.instr_if = '0; bus.pc_if = '0; bus.pred_taken_if = 1'b0;

        // Reset for two cycles, then the idle queue must look empty with zeroed data.
        cycle(1, 0, 0, 0, 64'h0, 0);
        cycle(1, 0, 0, 0, 64'h0, 0);
        cycle(0, 0, 0, 0, 64'h0, 0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_valid", 64'(bus.valid_id), 64'd0);
        check("rst_full",  64'(bus.full), 64'd0);
        check("rst_instr", 64'(bus.instr_id), 64'd0);
        check("rst_pc",    bus.pc_id, 64'd0);

        // Fill without consuming; a fifth push must be dropped.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 64'h100 + 64'(4 * i), 0);
        cycle(0, 0, 0, 1, 64'h110, 0);
        check("fill_full",  64'(bus.full), 64'd1);
        check("fill_count", 64'(bus.count), 64'd4);

        // Drain while IF keeps pushing; the first push is blocked by full.
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 64'h110 + 64'(4 * i), 1);
            if (i == 0) check("drain_count0", 64'(bus.count), 64'd4);
            check("drain_pc", bus.pc_id, 64'h100 + 64'(4 * i));
        end

        // Freeze holds the head while a push still lands; flush then wins over freeze.
        cycle(0, 0, 1, 1, 64'h120, 1);
        check("frz_count_before", 64'(bus.count), 64'd3);
        check("frz_pc_before",    bus.pc_id, 64'h114);
        cycle(0, 1, 1, 0, 64'h124, 1);
        check("frz_count_after", 64'(bus.count), 64'd4);
        check("frz_pc_after",    bus.pc_id, 64'h114);
        cycle(0, 0, 0, 0, 64'h0, 0);
        check("flush_count", 64'(bus.count), 64'd0);
        check("flush_valid", 64'(bus.valid_id), 64'd0);

        // Steady push+pop at occupancy 2 keeps count and FIFO order.
        cycle(0, 0, 0, 1, 64'h300, 0);
        cycle(0, 0, 0, 1, 64'h304, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1, 64'h308 + 64'(4 * i), 1);
            check("pp_count", 64'(bus.count), 64'd2);
            check("pp_pc",    bus.pc_id, 64'h300 + 64'(4 * i));
        end
        cycle(0, 1, 0, 0, 64'h0, 0);

        // Push into an empty queue with ID ready.
        cycle(0, 0, 0, 1, 64'h200, 1);
`ifdef IF_ID_QUEUE_BYPASS_EN
        check("byp_valid", 64'(bus.valid_id), 64'd1);
        check("byp_pc",    bus.pc_id, 64'h200);
        cycle(0, 0, 0, 0, 64'h0, 1);
        check("byp_count_after", 64'(bus.count), 64'd0);
        check("byp_valid_after", 64'(bus.valid_id), 64'd0);
`else
        check("lat_valid", 64'(bus.valid_id), 64'd0);
        cycle(0, 0, 0, 0, 64'h0, 1);
        check("lat_valid_next", 64'(bus.valid_id), 64'd1);
        check("lat_pc_next",    bus.pc_id, 64'h200);
`endif

        // Randomized traffic including occasional reset, flush and freeze.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) != 0),
                  {$urandom, $urandom},
                  ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
